// File: rtl/usb_rx_phy.sv
// usb_rx_phy: full-speed USB receive front end (4x oversampled from clk48).
// Ports: clk48/rst_n; raw usb_d_p/usb_d_n pins; rx_enable arms the receiver.
//        Byte stream out on rx_data/rx_valid, plus rx_active, rx_eop, rx_error strobes.
// Latency: rx_valid one clk48 after the sampling edge of the 8th bit; no backpressure (strobes only).
module usb_rx_phy #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int SAMPLE_PHASE   = 2,
  parameter int IDLE_BITS      = 8
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usb_d_p,
  input  logic       usb_d_n,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  // Line states as {D+, D-}
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_EOP   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam int         ICW      = $clog2(IDLE_BITS + 1);
  localparam logic [1:0] SAMP_PH  = 2'(SAMPLE_PHASE);
  localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_BITS - 1);

  logic [1:0]     dp_sync, dn_sync;   // [0] first stage, [1] second stage
  logic [1:0]     line, line_q;
  logic [1:0]     phase_q, phase;
  logic           sample, is_jk, dec_bit, fault;
  logic [1:0]     prev_jk;
  logic [2:0]     state;
  logic [2:0]     zero_cnt, stuff_cnt, bit_cnt;
  logic [ICW-1:0] idle_cnt;
  logic [7:0]     shift;

  // Two-flop synchronizers; they come out of reset showing an idle (J) bus.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      dp_sync <= 2'b11;
      dn_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], usb_d_p};
      dn_sync <= {dn_sync[0], usb_d_n};
    end
  end

  assign line = {dp_sync[1], dn_sync[1]};

  // Any line change realigns the bit clock: that cycle counts as phase 0,
  // so the sample lands mid-bit two cycles after each transition.
  assign phase   = (line != line_q) ? 2'd0 : phase_q;
  assign sample  = rx_enable && (phase == SAMP_PH);
  assign is_jk   = (line == LS_J) || (line == LS_K);
  assign dec_bit = (line == prev_jk);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= LS_J;
      phase_q <= 2'd0;
    end else begin
      line_q  <= line;
      phase_q <= rx_enable ? phase + 2'd1 : 2'd0;
    end
  end

  // Samples that kill the current packet and send the receiver to ABORT.
  always_comb begin
    fault = 1'b0;
    if (sample) begin
      case (state)
        ST_SYNC: fault = (line == LS_SE1) || (is_jk && dec_bit && (zero_cnt < SYNC_MIN));
        ST_DATA: fault = (line == LS_SE1) || (is_jk && dec_bit && (stuff_cnt == 3'd6));
        ST_EOP:  fault = (line == LS_SE1) || (line == LS_K);
        default: fault = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prev_jk   <= LS_J;
      zero_cnt  <= 3'd0;
      stuff_cnt <= 3'd0;
      bit_cnt   <= 3'd0;
      idle_cnt  <= '0;
      shift     <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_eop    <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_enable) begin
        // Silent drop: no strobes, everything back to a fresh idle receiver.
        state     <= ST_IDLE;
        rx_active <= 1'b0;
        prev_jk   <= LS_J;
        zero_cnt  <= 3'd0;
        stuff_cnt <= 3'd0;
        bit_cnt   <= 3'd0;
        idle_cnt  <= '0;
        shift     <= 8'd0;
      end else if (sample) begin
        if (is_jk) prev_jk <= line;
        if (fault) begin
          rx_error  <= 1'b1;
          rx_active <= 1'b0;
          state     <= ST_ABORT;
          idle_cnt  <= '0;
          bit_cnt   <= 3'd0;
          stuff_cnt <= 3'd0;
        end else begin
          case (state)
            ST_IDLE: begin
              // The J->K edge that starts SYNC is itself the first decoded 0.
              if (line == LS_K) begin
                state    <= ST_SYNC;
                zero_cnt <= 3'd1;
              end
            end
            ST_SYNC: begin
              if (line == LS_SE0) begin
                state   <= ST_IDLE;
                prev_jk <= LS_J;
              end else if (is_jk) begin
                if (!dec_bit) begin
                  if (zero_cnt != 3'd7) zero_cnt <= zero_cnt + 3'd1;
                end else begin
                  // Terminating 1 of SYNC already counts toward the stuff run.
                  state     <= ST_DATA;
                  rx_active <= 1'b1;
                  stuff_cnt <= 3'd1;
                  bit_cnt   <= 3'd0;
                end
              end
            end
            ST_DATA: begin
              if (line == LS_SE0) begin
                state <= ST_EOP;  // bit_cnt is kept as the residual count
              end else if (stuff_cnt == 3'd6) begin
                stuff_cnt <= 3'd0;  // stuffed 0, dropped
              end else begin
                shift     <= {dec_bit, shift[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
                stuff_cnt <= dec_bit ? stuff_cnt + 3'd1 : 3'd0;
                if (bit_cnt == 3'd7) begin
                  rx_valid <= 1'b1;
                  rx_data  <= {dec_bit, shift[7:1]};
                end
              end
            end
            ST_EOP: begin
              if (line == LS_J) begin
                // 0 or 1 leftover bits is normal dribble; more is an error.
                rx_eop    <= 1'b1;
                rx_error  <= (bit_cnt >= 3'd2);
                rx_active <= 1'b0;
                state     <= ST_IDLE;
                bit_cnt   <= 3'd0;
                stuff_cnt <= 3'd0;
              end
            end
            ST_ABORT: begin
              if (line == LS_J) begin
                if (idle_cnt == IDLE_LAST) begin
                  state    <= ST_IDLE;
                  idle_cnt <= '0;
                end else begin
                  idle_cnt <= idle_cnt + ICW'(1);
                end
              end else begin
                idle_cnt <= '0;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/usb_rx_phy.md
Name: usb_rx_phy

Overview:
- Full-speed (12 Mb/s) USB receive front end, clocked from clk48 with 4x oversampling.
- Synchronizes the raw D+/D- pins, recovers bit timing, NRZI-decodes and bit-unstuffs the stream, detects SYNC and EOP, and delivers packet bytes LSB-first-assembled with strobes.
- Sits directly upstream of the usb packet handler, which consumes its byte stream and fills usb_data_buffer.

Parameters:
- SYNC_MIN_ZEROS, 5: minimum decoded 0s before the SYNC-terminating 1 (tolerates hub-dropped SYNC bits).
- SAMPLE_PHASE, 2: phase-counter value (0..3) at which a bit is sampled.
- IDLE_BITS, 8: consecutive J samples needed to leave ABORT.

Ports:
- clk48  input  1  48 MHz clock
- rst_n  input  1  asynchronous active-low reset
- usb_d_p  input  1  raw D+ pin (asynchronous)
- usb_d_n  input  1  raw D- pin (asynchronous)
- rx_enable  input  1  1 = receiver armed; 0 = ignore line (e.g. during transmit)
- rx_data  output  8  received byte, valid only while rx_valid=1
- rx_valid  output  1  one-cycle strobe, one per completed byte
- rx_active  output  1  high from SYNC completion to EOP/abort
- rx_eop  output  1  one-cycle strobe on valid end of packet
- rx_error  output  1  one-cycle strobe on stuff, SE1, SYNC or residual-bit error

Behaviour:
- Reset, asynchronous:
  - All outputs 0.
  - State IDLE, previous line state = J, phase counter 0, all shift and bit counters 0.
- Input synchronization and line states:
  - Each pin passes through a 2-flop synchronizer.
  - Line states: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- Bit timing:
  - 2-bit phase counter increments mod 4 every clk48.
  - The counter is forced to 0 in any cycle where the synchronized line state differs from its value the previous cycle.
  - A bit sample is taken in the cycle where phase == SAMPLE_PHASE.
- NRZI decoding: a J/K sample decodes to 1 if it equals the previous J/K sample and to 0 otherwise. The previous sample updates only on J/K samples.
- IDLE:
  - A K sample moves to SYNC, with zero count = 1 (the J->K transition is a decoded 0).
  - SE0 and J samples are ignored.
- SYNC:
  - Each decoded 0 increments the zero count (saturating at 7).
  - A decoded 1 with zero count >= SYNC_MIN_ZEROS moves to DATA and sets rx_active=1. The stuff counter starts at 1, counting the terminating 1.
  - A decoded 1 with zero count < SYNC_MIN_ZEROS pulses rx_error and moves to ABORT.
- DATA:
  - Decoded bits shift in LSB first; a 3-bit bit counter increments per data bit.
  - When the 8th bit is sampled, the next clk48 cycle drives rx_valid=1 with rx_data = the assembled byte. Latency is 1 cycle after the sampling edge.
  - Bit unstuffing: the stuff counter counts consecutive decoded 1s.
  - After six 1s, the next bit must be 0; it is discarded and does not advance the bit counter.
  - If that bit is a 1, pulse rx_error, drop rx_active and move to ABORT.
  - A partially assembled byte is discarded.
- EOP:
  - An SE0 sample in DATA moves to EOP_WAIT.
  - In EOP_WAIT, a J sample pulses rx_eop, drops rx_active and returns to IDLE.
  - If the residual bit count at SE0 is 0 or 1 (dribble bit, discarded), only rx_eop pulses.
  - If the residual bit count is 2..7, rx_error and rx_eop pulse in the same cycle.
  - Further SE0 samples stay in EOP_WAIT.
  - A K sample in EOP_WAIT pulses rx_error and moves to ABORT.
- SE1:
  - An SE1 sample in SYNC, DATA or EOP_WAIT pulses rx_error, drops rx_active and moves to ABORT.
  - SE1 is ignored in IDLE.
- ABORT:
  - Leave to IDLE after IDLE_BITS consecutive J samples; any non-J sample resets that count.
  - No outputs are generated in ABORT.
- rx_enable=0:
  - Synchronously forces IDLE and clears rx_active.
  - Previous line state resets to J and all counters clear.
  - No eop/error pulse is generated, and a packet in progress is silently dropped.
- Simultaneous events:
  - rx_valid for the final byte and rx_eop are never in the same cycle, because EOP needs at least one later sample.
  - rx_error has priority over rx_valid: a stuff error on the bit after the 8th still delivers the completed byte first.

Test Plan:
- Clean packet: KJKJKJKK SYNC, then PID 0xA5, then 0x3C, then SE0 SE0 J, each bit 4 clk48 wide. Required: rx_valid twice with rx_data 0xA5 then 0x3C, rx_eop=1 once, rx_error never, rx_active high from the SYNC end to the EOP.
- Stuffing: SYNC, then byte 0xFF with the stuffed 0 inserted after six 1s, then 0x01, then EOP. Required: bytes 0xFF then 0x01, no error.
- Stuff error: SYNC, then seven consecutive decoded 1s. Required: rx_error pulse, rx_active=0, no rx_valid for the partial byte, ABORT until 8 J bit times.
- Clock drift: transmitter period of 4 or 5 clk48 cycles, alternating, for a 0x55 0xAA payload. Required: both bytes received correctly.
- Residual bits: SYNC, 0x12, 3 extra bits, then EOP. Required: rx_valid 0x12, then rx_error and rx_eop in the same cycle. With only 1 extra bit: rx_eop only.
- Mid-packet disable and reset: drop rx_enable after the first byte, then re-enable and send a full packet. Required: no eop/error from the first packet, and the second packet is received fully. Asserting rst_n=0 mid-byte clears all outputs immediately.
